// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron host link: frame header, framer FSM
// states and the byte-index width helper.
package perceptron_pkg;

  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_e;

  // A frame is header + tag + data bytes + checksum.
  function automatic int idx_width(input int word_bytes);
    return $clog2(word_bytes + 3);
  endfunction

endpackage

// File: rtl/resp_shift.sv
// Response byte source: holds the captured tag and data word, shifts data out
// MSB first and keeps a running mod-256 checksum over tag and data bytes.
module resp_shift #(
  parameter int          WORD_BYTES = 2,
  parameter logic [7:0]  HDR        = perceptron_pkg::HDR,
  parameter int          IW         = perceptron_pkg::idx_width(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    capture,
  input  logic [3:0]              sel,
  input  logic [8*WORD_BYTES-1:0] data,
  input  logic                    advance,
  input  logic [IW-1:0]           idx,
  output logic [7:0]              cur_byte
);

  localparam int DW = 8 * WORD_BYTES;
  localparam logic [IW-1:0] TAG_IDX   = IW'(1);
  localparam logic [IW-1:0] LAST_DATA = IW'(WORD_BYTES + 1);
  localparam logic [IW-1:0] CSUM_IDX  = IW'(WORD_BYTES + 2);

  logic [3:0]    tag_q;
  logic [DW-1:0] shift_q;
  logic [7:0]    csum_q;
  logic          in_sum;
  logic          is_data;

  assign in_sum  = (idx >= TAG_IDX) && (idx <= LAST_DATA);
  assign is_data = (idx >  TAG_IDX) && (idx <= LAST_DATA);

  // NOTE: default assignment first so every path drives cur_byte; no latch.
  always_comb begin
    cur_byte = shift_q[DW-1 -: 8];
    if (idx == '0)            cur_byte = HDR;
    else if (idx == TAG_IDX)  cur_byte = {4'h0, tag_q};
    else if (idx == CSUM_IDX) cur_byte = csum_q;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      tag_q   <= '0;
      shift_q <= '0;
      csum_q  <= '0;
    end else if (capture) begin
      tag_q   <= sel;
      shift_q <= data;
      csum_q  <= '0;
    end else if (advance) begin
      // The checksum byte is read only after every summed byte was loaded.
      if (in_sum)  csum_q  <= csum_q + cur_byte;
      if (is_data) shift_q <= shift_q << 8;
    end
  end

endmodule

// File: rtl/resp_tx.sv
// Response framer: serialises one tagged result word as
// HDR, tag, data (MSB first), checksum into a byte-wide uart with busy handshake.
module resp_tx #(
  parameter int         WORD_BYTES = 2,
  parameter logic [7:0] HDR        = perceptron_pkg::HDR,
  parameter int         TMO        = 15
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    req,
  input  logic [3:0]              req_sel,
  input  logic [8*WORD_BYTES-1:0] req_data,
  output logic                    ready,
  input  logic                    uart_busy,
  output logic [7:0]              uart_data,
  output logic                    uart_send,
  output logic                    done,
  output logic                    err
);
  import perceptron_pkg::*;

  localparam int            IW       = idx_width(WORD_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES + 2);
  localparam logic [3:0]    TMO_CNT  = 4'(TMO);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [3:0]    tmo_q;
  logic          ready_q;
  logic          send_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    data_q;
  logic [7:0]    cur_byte;
  logic          accept;

  assign accept    = req && ready_q;
  assign ready     = ready_q;
  assign uart_data = data_q;
  assign uart_send = send_q;
  assign done      = done_q;
  assign err       = err_q;

  resp_shift #(
    .WORD_BYTES (WORD_BYTES),
    .HDR        (HDR),
    .IW         (IW)
  ) u_shift (
    .clk      (clk),
    .nRst     (nRst),
    .capture  (accept),
    .sel      (req_sel),
    .data     (req_data),
    .advance  (state_q == LOAD),
    .idx      (idx_q),
    .cur_byte (cur_byte)
  );

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      ready_q <= 1'b1;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          data_q  <= cur_byte;
          state_q <= SEND;
        end
        SEND: begin
          // A uart still busy from elsewhere holds us here without a pulse.
          if (!uart_busy) begin
            send_q  <= 1'b1;
            tmo_q   <= '0;
            state_q <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (uart_busy) begin
            state_q <= WAIT_LO;
          end else if (tmo_q + 4'd1 == TMO_CNT) begin
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 4'd1;
          end
        end
        WAIT_LO: begin
          if (!uart_busy) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= LOAD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resp_tx.sv
// Scoreboard bench for resp_tx: stimulus pushes expected frame bytes, a
// negedge monitor pops and compares on every uart_send; a small uart model drives busy.
module tb_resp_tx;

  logic        clk = 1'b0;
  logic        nRst;
  logic        req;
  logic [3:0]  req_sel;
  logic [15:0] req_data;
  logic        ready;
  logic        uart_busy;
  logic [7:0]  uart_data;
  logic        uart_send;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  resp_tx #(
    .WORD_BYTES (2),
    .HDR        (8'hA5),
    .TMO        (15)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .req       (req),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .ready     (ready),
    .uart_busy (uart_busy),
    .uart_data (uart_data),
    .uart_send (uart_send),
    .done      (done),
    .err       (err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q[$];

  int   cyc           = 0;
  int   send_cnt      = 0;
  int   done_cnt      = 0;
  int   err_cnt       = 0;
  int   busy_viol     = 0;
  int   last_send_cyc = 0;
  int   last_err_cyc  = 0;
  logic prev_busy     = 1'b0;

  bit dead      = 1'b0;
  int hold_req  = 0;
  int busy_cnt  = 0;
  bit arm       = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // uart model: busy rises the cycle after a send pulse and stays up 10 cycles.
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) uart_busy = 1'b0;
      end
      if (hold_req > 0) begin
        uart_busy = 1'b1;
        busy_cnt  = hold_req;
        hold_req  = 0;
      end
      if (arm) begin
        uart_busy = 1'b1;
        busy_cnt  = 10;
        arm       = 1'b0;
      end
      if (uart_send && !dead) arm = 1'b1;
    end
  end

  // Monitor: compare every sent byte against the scoreboard, count pulses.
  initial forever begin
    @(negedge clk);
    if (uart_send) begin
      send_cnt++;
      last_send_cyc = cyc;
      if (prev_busy) busy_viol++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_send: got byte %0h, required no send", uart_data);
      end else begin
        check("frame_byte", {24'h0, uart_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    prev_busy = uart_busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [3:0] sel, input logic [15:0] data,
                            input logic [7:0] csum, input int nbytes);
    logic [7:0] b[5];
    b[0] = 8'hA5;
    b[1] = {4'h0, sel};
    b[2] = data[15:8];
    b[3] = data[7:0];
    b[4] = csum;
    for (int i = 0; i < nbytes; i++) exp_q.push_back(b[i]);
  endtask

  task automatic issue(input logic [3:0] sel, input logic [15:0] data);
    req_sel  = sel;
    req_data = data;
    req      = 1'b1;
    tick(1);
    req      = 1'b0;
  endtask

  task automatic wait_end(input string name, input int d0, input int e0);
    int i;
    for (i = 0; i < 600 && done_cnt == d0 && err_cnt == e0; i++) tick(1);
    if (done_cnt == d0 && err_cnt == e0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got no done/err in 600 cycles, required one", name);
    end
  endtask

  task automatic wait_quiet(input string name);
    int i;
    for (i = 0; i < 600 && !(ready && !uart_busy && busy_cnt == 0 && !arm); i++) tick(1);
    if (!(ready && !uart_busy)) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_quiet: got ready=%0b busy=%0b, required 1/0", name, ready, uart_busy);
    end
  endtask

  task automatic frame(input string name, input logic [3:0] sel, input logic [15:0] data,
                       input logic [7:0] csum, input int nsent, input int ndone, input int nerr);
    int d0, e0, s0;
    d0 = done_cnt;
    e0 = err_cnt;
    s0 = send_cnt;
    push_frame(sel, data, csum, nsent);
    issue(sel, data);
    wait_end(name, d0, e0);
    tick(2);
    check($sformatf("%s_sends", name), send_cnt - s0, nsent);
    check($sformatf("%s_done",  name), done_cnt - d0, ndone);
    check($sformatf("%s_err",   name), err_cnt - e0, nerr);
    check($sformatf("%s_ready", name), {31'h0, ready}, 32'h1);
    wait_quiet(name);
  endtask

  initial begin
    int d0, e0, s0, v0, i;
    nRst     = 1'b0;
    req      = 1'b0;
    req_sel  = 4'h0;
    req_data = 16'h0;
    tick(3);
    check("rst_ready", {31'h0, ready},     32'h1);
    check("rst_send",  {31'h0, uart_send}, 32'h0);
    check("rst_data",  {24'h0, uart_data}, 32'h0);
    check("rst_done",  {31'h0, done},      32'h0);
    check("rst_err",   {31'h0, err},       32'h0);
    nRst = 1'b1;
    tick(2);

    // Basic frame and all-ones frame with checksum wrap (0x20D -> 0D).
    frame("basic", 4'h3, 16'h1234, 8'h49, 5, 1, 0);
    frame("ones",  4'hF, 16'hFFFF, 8'h0D, 5, 1, 0);

    // uart busy from elsewhere when the frame starts.
    hold_req = 20;
    tick(2);
    v0 = busy_viol;
    frame("held", 4'hA, 16'h5A5A, 8'hBE, 5, 1, 0);
    check("held_no_send_while_busy", busy_viol - v0, 0);

    // uart never answers: header goes out, then timeout abort.
    dead = 1'b1;
    frame("tmo", 4'h6, 16'h0000, 8'h06, 1, 0, 1);
    check("tmo_latency", last_err_cyc - last_send_cyc, 15);
    dead = 1'b0;
    frame("after_tmo", 4'h1, 16'hABCD, 8'h79, 5, 1, 0);

    // Second request while busy framing is dropped.
    d0 = done_cnt;
    e0 = err_cnt;
    s0 = send_cnt;
    push_frame(4'h3, 16'h1234, 8'h49, 5);
    issue(4'h3, 16'h1234);
    tick(8);
    issue(4'h5, 16'h9999);
    wait_end("midreq", d0, e0);
    wait_quiet("midreq");
    tick(30);
    check("midreq_sends", send_cnt - s0, 5);
    check("midreq_done",  done_cnt - d0, 1);
    check("midreq_err",   err_cnt - e0, 0);

    // Reset after byte index 2 has been sent.
    d0 = done_cnt;
    e0 = err_cnt;
    s0 = send_cnt;
    push_frame(4'h2, 16'h0102, 8'h00, 3);
    issue(4'h2, 16'h0102);
    for (i = 0; i < 600 && send_cnt < s0 + 3; i++) tick(1);
    check("rstmid_reached_byte2", send_cnt - s0, 3);
    nRst = 1'b0;
    tick(1);
    nRst = 1'b1;
    check("rstmid_ready", {31'h0, ready},     32'h1);
    check("rstmid_send",  {31'h0, uart_send}, 32'h0);
    check("rstmid_data",  {24'h0, uart_data}, 32'h0);
    check("rstmid_done",  {31'h0, done},      32'h0);
    check("rstmid_err",   {31'h0, err},       32'h0);
    tick(40);
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_no_err",  err_cnt - e0, 0);
    check("rstmid_sends",   send_cnt - s0, 3);
    wait_quiet("rstmid");
    frame("after_rst", 4'h9, 16'h8001, 8'h8A, 5, 1, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
